// File: rtl/prefetch_pattern_detector_pkg.sv
// Prefetch types shared by the detector and the issuer: line addresses, stride codes,
// access/pattern records, training state, and a lowest-index priority encoder.
package prefetch_pattern_detector_pkg;

   localparam int PF_ADDR_W = 12;
   typedef logic [PF_ADDR_W-1:0] PFAddr_t;

   // Two's-complement line deltas; zero is not a stride.
   typedef enum logic [2:0] {
      STRIDE_M_TWO = 3'b110,
      STRIDE_M_ONE = 3'b111,
      STRIDE_ONE   = 3'b001,
      STRIDE_TWO   = 3'b010
   } PFStride_t;

   typedef enum logic [1:0] {
      INVALID = 2'd0,
      TRAIN   = 2'd1,
      TRACKED = 2'd2
   } PFTrainState_t;

   typedef struct packed {
      PFAddr_t addr;
      logic    valid;
   } PrefetchAccess;

   typedef struct packed {
      PFAddr_t   addr;
      PFStride_t stride;
      logic      valid;
   } PrefetchPattern;

   localparam int PE_W = 16;
   typedef struct packed {
      logic       found;
      logic [3:0] idx;
   } PrioResult_t;

   function automatic PrioResult_t prio_lowest(input logic [PE_W-1:0] req);
      PrioResult_t r;
      r = '0;
      for (int i = PE_W - 1; i >= 0; i--) begin
         if (req[i]) begin
            r.found = 1'b1;
            r.idx   = 4'(i);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/prefetch_pattern_detector.sv
// Trains +-1/+-2 line stride detectors on demand accesses and pulses one confirmed pattern.
// Access to pattern is 2 cycles (input register, then table update + output register); no backpressure.
module prefetch_pattern_detector
   import prefetch_pattern_detector_pkg::*;
#(
   parameter int NUM_ACCESS  = 2,
   parameter int NUM_ENTRIES = 8,
   parameter int CONF_THRESH = 2,
   parameter int AGE_LEN     = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  PrefetchAccess  IN_access [NUM_ACCESS],
   output PrefetchPattern OUT_pattern
);

   localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
   localparam int CONF_W = $clog2(CONF_THRESH + 1);
   localparam logic [AGE_LEN-1:0] AGE_MAX = '1;

   typedef struct packed {
      PFTrainState_t      state;
      PFAddr_t            addr;
      logic [2:0]         stride;
      logic [CONF_W-1:0]  conf;
      logic [AGE_LEN-1:0] age;
   } entry_t;

   PrefetchAccess          r_s0 [NUM_ACCESS];
   entry_t                 r_tab [NUM_ENTRIES];
   logic [IDX_W-1:0]       r_ptr;
   PrefetchPattern         r_out;

   entry_t                 w_tab_nxt [NUM_ENTRIES];
   PrefetchPattern         w_out;
   logic [IDX_W-1:0]       w_ptr_nxt;
   logic [NUM_ENTRIES-1:0] w_hit [NUM_ACCESS];
   logic [NUM_ENTRIES-1:0] w_claimed;
   logic [NUM_ENTRIES-1:0] w_free;
   logic [NUM_ENTRIES-1:0] w_aged;

   // Near match: modular delta in [-2,+2], i.e. (d + 2) mod 2^W <= 4.
   always_comb begin
      for (int a = 0; a < NUM_ACCESS; a++) begin
         for (int e = 0; e < NUM_ENTRIES; e++) begin
            w_hit[a][e] = r_s0[a].valid && (r_tab[e].state != INVALID) &&
                          ((r_s0[a].addr - r_tab[e].addr + PFAddr_t'(2)) <= PFAddr_t'(4));
         end
      end
   end

   always_comb begin : p_train
      PrioResult_t      pe;
      logic [IDX_W-1:0] e;
      logic [IDX_W-1:0] vic;
      logic [IDX_W-1:0] rr_idx;
      logic [2:0]       d;
      logic             emitted;
      logic             alloc;
      logic             vic_found;
      PFAddr_t          alloc_addr;

      w_tab_nxt  = r_tab;
      w_out      = '0;
      w_ptr_nxt  = r_ptr;
      w_claimed  = '0;
      w_free     = '0;
      w_aged     = '0;
      pe         = '0;
      e          = '0;
      vic        = '0;
      rr_idx     = '0;
      d          = '0;
      emitted    = 1'b0;
      alloc      = 1'b0;
      vic_found  = 1'b0;
      alloc_addr = '0;

      for (int a = 0; a < NUM_ACCESS; a++) begin
         pe = prio_lowest(PE_W'(w_hit[a]));
         e  = IDX_W'(pe.idx);
         d  = 3'(r_s0[a].addr - r_tab[e].addr);
         if (r_s0[a].valid && !pe.found) begin
            if (!alloc) begin
               alloc      = 1'b1;
               alloc_addr = r_s0[a].addr;
            end
         end else if (pe.found && !w_claimed[e]) begin
            w_claimed[e] = 1'b1;
            if (d == 3'd0) begin
               w_tab_nxt[e].age = '0;
            end else if (r_tab[e].state == TRACKED) begin
               if (d == r_tab[e].stride) w_tab_nxt[e].addr = r_s0[a].addr;
               w_tab_nxt[e].age = '0;
            end else if (r_tab[e].conf == '0 || d != r_tab[e].stride) begin
               w_tab_nxt[e].stride = d;
               w_tab_nxt[e].conf   = CONF_W'(1);
               w_tab_nxt[e].addr   = r_s0[a].addr;
               w_tab_nxt[e].age    = '0;
            end else if (int'(r_tab[e].conf) + 1 >= CONF_THRESH && !emitted) begin
               emitted = 1'b1;
               w_out   = '{addr: r_s0[a].addr, stride: PFStride_t'(d), valid: 1'b1};
               w_tab_nxt[e].state = TRACKED;
               w_tab_nxt[e].addr  = r_s0[a].addr;
            end else if (int'(r_tab[e].conf) + 1 >= CONF_THRESH) begin
               // Lost the single output slot: stay TRAIN so the next match emits.
               w_tab_nxt[e].addr = r_s0[a].addr;
               w_tab_nxt[e].age  = '0;
            end else begin
               w_tab_nxt[e].conf = r_tab[e].conf + 1'b1;
               w_tab_nxt[e].addr = r_s0[a].addr;
               w_tab_nxt[e].age  = '0;
            end
         end
      end

      for (int i = 0; i < NUM_ENTRIES; i++) begin
         w_free[i] = !w_claimed[i] && (r_tab[i].state == INVALID);
         w_aged[i] = !w_claimed[i] && (r_tab[i].state != INVALID) && (r_tab[i].age == AGE_MAX);
      end

      if (alloc) begin
         pe = prio_lowest(PE_W'(w_free));
         if (pe.found) begin
            vic_found = 1'b1;
            vic       = IDX_W'(pe.idx);
         end else begin
            pe = prio_lowest(PE_W'(w_aged));
            if (pe.found) begin
               vic_found = 1'b1;
               vic       = IDX_W'(pe.idx);
            end else begin
               // Round-robin from the pointer, skipping entries updated this cycle.
               for (int k = NUM_ENTRIES - 1; k >= 0; k--) begin
                  rr_idx = r_ptr + IDX_W'(k);
                  if (!w_claimed[rr_idx]) begin
                     vic_found = 1'b1;
                     vic       = rr_idx;
                  end
               end
               if (vic_found) w_ptr_nxt = vic + 1'b1;
            end
         end
      end

      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (!w_claimed[i] && r_tab[i].state != INVALID) begin
            if (r_tab[i].state == TRACKED && r_tab[i].age == AGE_MAX) begin
               w_tab_nxt[i].state = INVALID;
            end else if (r_tab[i].age != AGE_MAX) begin
               w_tab_nxt[i].age = r_tab[i].age + 1'b1;
            end
         end
      end

      if (alloc && vic_found) begin
         w_tab_nxt[vic] = '{state: TRAIN, addr: alloc_addr, stride: 3'd0, conf: '0, age: '0};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int a = 0; a < NUM_ACCESS; a++) r_s0[a] <= '0;
         for (int i = 0; i < NUM_ENTRIES; i++) r_tab[i] <= '0;
         r_ptr <= '0;
         r_out <= '0;
      end else begin
         r_s0  <= IN_access;
         r_tab <= w_tab_nxt;
         r_ptr <= w_ptr_nxt;
         r_out <= w_out;
      end
   end

   assign OUT_pattern = r_out;

endmodule

// File: tb/tb_prefetch_pattern_detector.sv
// Randomized and directed bench with an array-based reference model of the stride trainer.
module tb_prefetch_pattern_detector;
   import prefetch_pattern_detector_pkg::*;

   localparam int NA = 2, NE = 8, CT = 2, AL = 4, AMAX = 15, AW = 4096;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   PrefetchAccess  IN_access [NA];
   PrefetchPattern OUT_pattern;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   prefetch_pattern_detector #(
      .NUM_ACCESS(NA), .NUM_ENTRIES(NE), .CONF_THRESH(CT), .AGE_LEN(AL)
   ) dut (
      .clk(clk), .rst(rst), .IN_access(IN_access), .OUT_pattern(OUT_pattern)
   );

   // Model state: 0 invalid, 1 train, 2 tracked
   int m_state [NE], m_addr [NE], m_stride [NE], m_conf [NE], m_age [NE];
   int m_ptr;
   bit m_s0_v [NA];
   int m_s0_a [NA];
   bit m_out_v;
   int m_out_a, m_out_s;

   function automatic int delta(input int acc, input int base);
      int d;
      d = (acc - base) & (AW - 1);
      if (d >= AW / 2) d = d - AW;
      return d;
   endfunction

   task automatic model_reset();
      for (int e = 0; e < NE; e++) begin
         m_state[e] = 0; m_addr[e] = 0; m_stride[e] = 0; m_conf[e] = 0; m_age[e] = 0;
      end
      for (int a = 0; a < NA; a++) begin
         m_s0_v[a] = 1'b0; m_s0_a[a] = 0;
      end
      m_ptr = 0; m_out_v = 1'b0; m_out_a = 0; m_out_s = 0;
   endtask

   task automatic model_step();
      int os [NE], oa [NE], ost [NE], oc [NE], og [NE];
      bit claimed [NE];
      bit emitted, alloc;
      int alloc_a, hit, d, v, acc;
      for (int e = 0; e < NE; e++) begin
         os[e] = m_state[e]; oa[e] = m_addr[e]; ost[e] = m_stride[e];
         oc[e] = m_conf[e]; og[e] = m_age[e]; claimed[e] = 1'b0;
      end
      emitted = 1'b0; alloc = 1'b0; alloc_a = 0;
      m_out_v = 1'b0; m_out_a = 0; m_out_s = 0;
      for (int a = 0; a < NA; a++) begin
         if (!m_s0_v[a]) continue;
         acc = m_s0_a[a];
         hit = -1;
         for (int e = 0; e < NE; e++)
            if (hit < 0 && os[e] != 0 && delta(acc, oa[e]) >= -2 && delta(acc, oa[e]) <= 2) hit = e;
         if (hit < 0) begin
            if (!alloc) begin alloc = 1'b1; alloc_a = acc; end
            continue;
         end
         if (claimed[hit]) continue;
         claimed[hit] = 1'b1;
         d = delta(acc, oa[hit]);
         if (d == 0) begin
            m_age[hit] = 0;
         end else if (os[hit] == 2) begin
            if (d == ost[hit]) m_addr[hit] = acc;
            m_age[hit] = 0;
         end else if (oc[hit] == 0 || d != ost[hit]) begin
            m_stride[hit] = d; m_conf[hit] = 1; m_addr[hit] = acc; m_age[hit] = 0;
         end else if (oc[hit] + 1 >= CT) begin
            if (!emitted) begin
               emitted = 1'b1; m_out_v = 1'b1; m_out_a = acc; m_out_s = d;
               m_state[hit] = 2; m_addr[hit] = acc;
            end else begin
               m_addr[hit] = acc; m_age[hit] = 0;
            end
         end else begin
            m_conf[hit] = oc[hit] + 1; m_addr[hit] = acc; m_age[hit] = 0;
         end
      end
      v = -1;
      if (alloc) begin
         for (int e = 0; e < NE; e++) if (v < 0 && !claimed[e] && os[e] == 0) v = e;
         for (int e = 0; e < NE; e++) if (v < 0 && !claimed[e] && os[e] != 0 && og[e] == AMAX) v = e;
         if (v < 0) begin
            for (int k = 0; k < NE; k++) if (v < 0 && !claimed[(m_ptr + k) % NE]) v = (m_ptr + k) % NE;
            if (v >= 0) m_ptr = (v + 1) % NE;
         end
      end
      for (int e = 0; e < NE; e++) begin
         if (!claimed[e] && e != v && os[e] != 0) begin
            if (os[e] == 2 && og[e] == AMAX) m_state[e] = 0;
            else if (og[e] < AMAX) m_age[e] = og[e] + 1;
         end
      end
      if (v >= 0) begin
         m_state[v] = 1; m_addr[v] = alloc_a; m_stride[v] = 0; m_conf[v] = 0; m_age[v] = 0;
      end
   endtask

   always @(posedge clk) begin
      if (rst) begin
         model_reset();
      end else begin
         model_step();
         for (int a = 0; a < NA; a++) begin
            m_s0_v[a] = IN_access[a].valid;
            m_s0_a[a] = int'(IN_access[a].addr);
         end
      end
   end

   task automatic check_out(input string name, input bit ev, input int ea, input int es);
      logic signed [2:0] s;
      bit ok;
      s = OUT_pattern.stride;
      vectors++;
      ok = (OUT_pattern.valid === ev) &&
           (!ev || (int'(OUT_pattern.addr) == ea && int'(s) == es));
      if (!ok) begin
         miscompares++;
         $display("FAIL %s t=%0t: got vld=%b addr=%h stride=%0d, want vld=%0b addr=%h stride=%0d",
                  name, $time, OUT_pattern.valid, OUT_pattern.addr, s, ev, ea[11:0], es);
      end
   endtask

   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         check_out("model", m_out_v, m_out_a, m_out_s);
      end
   end

   task automatic cyc(input bit v0, input int a0, input bit v1, input int a1);
      IN_access[0].valid = v0; IN_access[0].addr = PFAddr_t'(a0);
      IN_access[1].valid = v1; IN_access[1].addr = PFAddr_t'(a1);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 0, 1'b0, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(1'b0, 0, 1'b0, 0);
      rst = 1'b0;
   endtask

   task automatic fill8();
      for (int i = 0; i < 8; i++) cyc(1'b1, 'h500 + 16 * i, 1'b0, 0);
   endtask

   initial begin
      int base [NA];
      int st [NA];
      int r;
      bit v0, v1;
      for (int a = 0; a < NA; a++) begin
         IN_access[a] = '0; base[a] = 0; st[a] = 1;
      end
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_out("reset", 1'b0, 0, 0);
      rst = 1'b0;

      // ascending stream confirms, then tracked stream stays quiet
      cyc(1, 'h100, 0, 0); cyc(1, 'h101, 0, 0); cyc(1, 'h102, 0, 0);
      cyc(1, 'h103, 0, 0);
      check_out("t1_pat", 1'b1, 'h102, 1);
      idle(1);
      check_out("t1_tracked", 1'b0, 0, 0);

      cyc(1, 'h200, 0, 0); cyc(1, 'h1FE, 0, 0); cyc(1, 'h1FC, 0, 0); idle(1);
      check_out("t2_neg2", 1'b1, 'h1FC, -2);
      cyc(1, 'h300, 0, 0); cyc(1, 'h301, 0, 0); cyc(1, 'h303, 0, 0); idle(1);
      check_out("t2_retrain", 1'b0, 0, 0);
      cyc(1, 'h305, 0, 0); idle(1);
      check_out("t2_plus2", 1'b1, 'h305, 2);

      cyc(1, 'h400, 1, 'h401); cyc(1, 'h401, 0, 0); idle(1);
      check_out("t3_conf1", 1'b0, 0, 0);
      cyc(1, 'h402, 0, 0); idle(1);
      check_out("t3_pat", 1'b1, 'h402, 1);

      do_reset(); fill8(); idle(16);
      cyc(1, 'h600, 0, 0); cyc(1, 'h501, 0, 0); cyc(1, 'h502, 0, 0); idle(1);
      check_out("t4_aged_evict", 1'b0, 0, 0);
      cyc(1, 'h601, 0, 0); cyc(1, 'h602, 0, 0); idle(1);
      check_out("t4_aged_alloc", 1'b1, 'h602, 1);

      do_reset(); fill8();
      cyc(1, 'h700, 0, 0); cyc(1, 'h710, 0, 0); cyc(1, 'h720, 0, 0);
      cyc(1, 'h531, 0, 0); cyc(1, 'h532, 0, 0); idle(1);
      check_out("t4_rr_keep3", 1'b1, 'h532, 1);
      cyc(1, 'h521, 0, 0); cyc(1, 'h522, 0, 0); idle(1);
      check_out("t4_rr_evict2", 1'b0, 0, 0);

      do_reset();
      cyc(1, 'h800, 0, 0); cyc(1, 'h900, 0, 0);
      cyc(1, 'h801, 1, 'h901); cyc(1, 'h802, 1, 'h902); idle(1);
      check_out("t5_port0_wins", 1'b1, 'h802, 1);
      cyc(1, 'h903, 0, 0); idle(1);
      check_out("t5_loser_emits", 1'b1, 'h903, 1);

      do_reset();
      cyc(1, 'hFFF, 0, 0); cyc(1, 'h000, 0, 0); cyc(1, 'h001, 0, 0); idle(1);
      check_out("t6_wrap", 1'b1, 'h001, 1);
      do_reset();
      cyc(1, 'h100, 0, 0); cyc(1, 'h101, 0, 0); cyc(1, 'h102, 0, 0);
      do_reset();
      check_out("t6_rst_kill", 1'b0, 0, 0);
      cyc(1, 'h100, 0, 0); do_reset(); cyc(1, 'h101, 0, 0); cyc(1, 'h102, 0, 0); idle(1);
      check_out("t6_rst_between", 1'b0, 0, 0);
      cyc(1, 'h103, 0, 0); idle(1);
      check_out("t6_after_rst", 1'b1, 'h103, 1);

      for (int n = 0; n < 3000; n++) begin
         for (int a = 0; a < NA; a++) begin
            if ($urandom_range(0, 15) == 0) begin
               base[a] = int'($urandom_range(0, AW - 1));
            end else begin
               if ($urandom_range(0, 7) == 0) begin
                  r = int'($urandom_range(0, 6));
                  st[a] = r - 3;
               end
               base[a] = (base[a] + st[a]) & (AW - 1);
            end
         end
         if ($urandom_range(0, 3) == 0) begin
            r = int'($urandom_range(0, 4));
            base[1] = (base[0] + r - 2) & (AW - 1);
         end
         v0 = ($urandom_range(0, 9) < 7);
         v1 = ($urandom_range(0, 9) < 5);
         if ($urandom_range(0, 499) == 0) rst = 1'b1;
         cyc(v0, base[0], v1, base[1]);
         rst = 1'b0;
         if ($urandom_range(0, 199) == 0) idle(20);
      end

      idle(3);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
